multi_word_loader: RTL and testbench

Parametrised serialiser that streams N_WORDS words of W bits each onto an 8-bit nibble bus, MSB nibble first. Each frame can end with an optional XOR checksum nibble. A one-deep pending slot lets the next frame be queued while the current one is sent, so consecutive frames go out back-to-back with no gap. It sits between the watchdog result registers and the byte-wide output pins, as the next-generation output stage for multi-word reports.

---
 rtl/multi_word_loader_pkg.sv | 33 +++
 rtl/multi_word_loader_if.sv | 19 +
 rtl/multi_word_loader_nibble_select.sv | 22 ++
 rtl/multi_word_loader.sv | 165 ++++++++++++++++
 tb/tb_multi_word_loader.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/multi_word_loader_pkg.sv
// Shared types, byte-field layout and helpers for the multi-word nibble serialiser.
package multi_word_loader_pkg;

  localparam int MODE_LSB  = 5;
  localparam int VALID_BIT = 4;
  localparam int NIB_W     = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_CHK  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    CHK  = ST_CHK
  } state_t;

  function automatic logic [7:0] pack_byte(input logic [2:0] mode,
                                           input logic [NIB_W-1:0] nibble);
    logic [7:0] b_s;
    b_s                 = 8'h00;
    b_s[7:MODE_LSB]     = mode;
    b_s[VALID_BIT]      = 1'b1;
    b_s[NIB_W-1:0]      = nibble;
    return b_s;
  endfunction

  function automatic logic [NIB_W-1:0] nib_xor(input logic [NIB_W-1:0] acc,
                                               input logic [NIB_W-1:0] nib);
    return acc ^ nib;
  endfunction

endpackage

// File: rtl/multi_word_loader_if.sv
// Request/output bundle of the multi-word loader; clock and reset stay plain ports.
interface multi_word_loader_if #(
  parameter int W       = 32,
  parameter int N_WORDS = 2
);
  logic                 ena;
  logic                 start;
  logic [2:0]           mode;
  logic [N_WORDS*W-1:0] words;
  logic                 ready;
  logic                 busy;
  logic [7:0]           out_byte;
  logic                 frame_end;

  modport master (output ena, start, mode, words,
                  input  ready, busy, out_byte, frame_end);
  modport slave  (input  ena, start, mode, words,
                  output ready, busy, out_byte, frame_end);
endinterface

// File: rtl/multi_word_loader_nibble_select.sv
// Picks nibble idx out of a W-bit word; idx 0 is the least significant nibble.
module nibble_select
  import multi_word_loader_pkg::*;
#(
  parameter  int W     = 32,
  localparam int NIB_N = W / NIB_W,
  localparam int IDX_W = (NIB_N > 1) ? $clog2(NIB_N) : 1
) (
  input  logic [W-1:0]     word,
  input  logic [IDX_W-1:0] idx,
  output logic [NIB_W-1:0] nibble
);

  // one-hot compare keeps out-of-range idx values harmless for non-power-of-two widths
  always_comb begin
    nibble = {NIB_W{1'b0}};
    for (int i = 0; i < NIB_N; i++) begin
      nibble = (idx == IDX_W'(i)) ? word[i*NIB_W +: NIB_W] : nibble;
    end
  end

endmodule

// File: rtl/multi_word_loader.sv
// Streams N_WORDS x W-bit frames onto a byte bus one nibble per byte, with an
// optional XOR checksum nibble and a one-deep pending slot for gapless frames.
module multi_word_loader
  import multi_word_loader_pkg::*;
#(
  parameter int W       = 32,
  parameter int N_WORDS = 2,
  parameter int CHK_EN  = 1
) (
  input logic               clk,
  input logic               rst_n,
  multi_word_loader_if.slave bus
);

  localparam int NIB_N = W / NIB_W;
  localparam int NB_W  = (NIB_N > 1) ? $clog2(NIB_N) : 1;
  localparam int NW_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int DW    = N_WORDS * W;
  localparam logic [NB_W-1:0] NIB_MAX  = NB_W'(NIB_N - 1);
  localparam logic [NW_W-1:0] WORD_MAX = NW_W'(N_WORDS - 1);

  if ((W % NIB_W) != 0 || W < NIB_W) begin : g_bad_w
    $error("multi_word_loader: W must be a multiple of 4 and at least 4");
  end
  if (N_WORDS < 1 || N_WORDS > 8) begin : g_bad_n
    $error("multi_word_loader: N_WORDS must be in 1..8");
  end

  state_t           state_r;
  logic [DW-1:0]    act_words_r;
  logic [2:0]       act_mode_r;
  logic [DW-1:0]    pend_words_r;
  logic [2:0]       pend_mode_r;
  logic             pend_valid_r;
  logic [NB_W-1:0]  nib_cnt_r;
  logic [NW_W-1:0]  word_cnt_r;
  logic [NIB_W-1:0] chk_r;
  logic             fin_r;
  logic [7:0]       out_byte_r;
  logic             frame_end_r;

  logic             pull_s;
  logic [DW-1:0]    src_words_s;
  logic [2:0]       src_mode_s;
  logic [NB_W-1:0]  src_nib_s;
  logic [NW_W-1:0]  src_word_s;
  logic [NIB_W-1:0] src_chk_s;
  logic [NW_W-1:0]  word_sel_s;
  logic [W-1:0]     cur_word_s;
  logic [NIB_W-1:0] nib_s;
  logic             last_data_s;

  // on the pull edge the pending frame's first nibble is emitted, so source everything from it
  always_comb begin
    pull_s      = fin_r & pend_valid_r;
    src_words_s = pull_s ? pend_words_r : act_words_r;
    src_mode_s  = pull_s ? pend_mode_r : act_mode_r;
    src_nib_s   = pull_s ? NIB_MAX : nib_cnt_r;
    src_word_s  = pull_s ? WORD_MAX : word_cnt_r;
    src_chk_s   = pull_s ? {NIB_W{1'b0}} : chk_r;
    word_sel_s  = WORD_MAX - src_word_s;
    cur_word_s  = {W{1'b0}};
    for (int i = 0; i < N_WORDS; i++) begin
      cur_word_s = (word_sel_s == NW_W'(i)) ? src_words_s[i*W +: W] : cur_word_s;
    end
    last_data_s = (src_nib_s == {NB_W{1'b0}}) && (src_word_s == {NW_W{1'b0}});
  end

  nibble_select #(.W(W)) u_nibble_select (
    .word   (cur_word_s),
    .idx    (src_nib_s),
    .nibble (nib_s)
  );

  // frame engine: accept, pending slot, nibble/word counters, checksum and output byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      act_words_r  <= {DW{1'b0}};
      act_mode_r   <= 3'd0;
      pend_words_r <= {DW{1'b0}};
      pend_mode_r  <= 3'd0;
      pend_valid_r <= 1'b0;
      nib_cnt_r    <= {NB_W{1'b0}};
      word_cnt_r   <= {NW_W{1'b0}};
      chk_r        <= {NIB_W{1'b0}};
      fin_r        <= 1'b0;
      out_byte_r   <= 8'h00;
      frame_end_r  <= 1'b0;
    end else if (!bus.ena) begin
      out_byte_r  <= 8'h00;
      frame_end_r <= 1'b0;
    end else begin
      out_byte_r  <= 8'h00;
      frame_end_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            act_words_r <= bus.words;
            act_mode_r  <= bus.mode;
            nib_cnt_r   <= NIB_MAX;
            word_cnt_r  <= WORD_MAX;
            chk_r       <= {NIB_W{1'b0}};
            fin_r       <= 1'b0;
            state_r     <= SEND;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND, CHK: begin
          if (bus.start && !pend_valid_r) begin
            pend_words_r <= bus.words;
            pend_mode_r  <= bus.mode;
            pend_valid_r <= 1'b1;
          end
          if (fin_r && !pend_valid_r) begin
            state_r <= IDLE;
            fin_r   <= 1'b0;
          end else if (state_r == CHK && !fin_r) begin
            out_byte_r  <= pack_byte(act_mode_r, chk_r);
            frame_end_r <= 1'b1;
            fin_r       <= 1'b1;
          end else begin
            out_byte_r <= pack_byte(src_mode_s, nib_s);
            chk_r      <= nib_xor(src_chk_s, nib_s);
            fin_r      <= 1'b0;
            if (pull_s) begin
              act_words_r  <= pend_words_r;
              act_mode_r   <= pend_mode_r;
              pend_valid_r <= 1'b0;
            end
            if (last_data_s) begin
              if (CHK_EN != 0) begin
                state_r <= CHK;
              end else begin
                state_r     <= SEND;
                frame_end_r <= 1'b1;
                fin_r       <= 1'b1;
              end
            end else begin
              state_r <= SEND;
              if (src_nib_s == {NB_W{1'b0}}) begin
                nib_cnt_r  <= NIB_MAX;
                word_cnt_r <= src_word_s - NW_W'(1);
              end else begin
                nib_cnt_r  <= src_nib_s - NB_W'(1);
                word_cnt_r <= src_word_s;
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
          fin_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ~pend_valid_r;
  assign bus.busy      = (state_r != IDLE);
  assign bus.out_byte  = out_byte_r;
  assign bus.frame_end = frame_end_r;

endmodule

// File: tb/tb_multi_word_loader.sv
// Directed, table-driven bench for multi_word_loader in two parameter sets.
module tb_multi_word_loader;
  import multi_word_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multi_word_loader_if #(.W(32), .N_WORDS(2)) ifa ();
  multi_word_loader_if #(.W(16), .N_WORDS(1)) ifb ();

  multi_word_loader #(.W(32), .N_WORDS(2), .CHK_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  multi_word_loader #(.W(16), .N_WORDS(1), .CHK_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  logic [31:0] ref_word;
  logic [2:0]  ref_idx;
  logic [3:0]  ref_nib;
  nibble_select #(.W(32)) u_ref_sel (.word(ref_word), .idx(ref_idx), .nibble(ref_nib));

  typedef struct {
    logic        ena;
    logic        start;
    logic [2:0]  mode;
    logic [63:0] words;
    logic [7:0]  exp_byte;
    logic        exp_fe;
    logic        exp_busy;
    logic        exp_ready;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] WA = {32'h9ABCDEF0, 32'h12345678};
  localparam logic [63:0] WB = {32'h00000000, 32'hFFFFFFFF};
  localparam logic [63:0] WX = {32'hDEADBEEF, 32'h0BADF00D};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic s, input logic [2:0] m, input logic [63:0] w,
                     input logic [7:0] b, input logic fe, input logic bz, input logic rd);
    vec_t v;
    v.ena = e; v.start = s; v.mode = m; v.words = w;
    v.exp_byte = b; v.exp_fe = fe; v.exp_busy = bz; v.exp_ready = rd;
    tbl.push_back(v);
  endtask

  task automatic idle_drive();
    ifa.ena = 1'b1; ifa.start = 1'b0; ifa.mode = 3'd0; ifa.words = 64'd0;
    ifb.ena = 1'b1; ifb.start = 1'b0; ifb.mode = 3'd0; ifb.words = 16'd0;
  endtask

  task automatic check_outs(input string tag, input int sel, input logic [7:0] b,
                            input logic fe, input logic bz, input logic rd);
    if (sel == 0) begin
      check({tag, ".byte"},  ifa.out_byte,  b);
      check({tag, ".fe"},    ifa.frame_end, fe);
      check({tag, ".busy"},  ifa.busy,      bz);
      check({tag, ".ready"}, ifa.ready,     rd);
    end else begin
      check({tag, ".byte"},  ifb.out_byte,  b);
      check({tag, ".fe"},    ifb.frame_end, fe);
      check({tag, ".busy"},  ifb.busy,      bz);
      check({tag, ".ready"}, ifb.ready,     rd);
    end
  endtask

  // drive one record just after a falling edge, sample at the next falling edge
  task automatic run_table(input int sel, input string tag);
    foreach (tbl[i]) begin
      if (sel == 0) begin
        ifa.ena = tbl[i].ena; ifa.start = tbl[i].start;
        ifa.mode = tbl[i].mode; ifa.words = tbl[i].words;
      end else begin
        ifb.ena = tbl[i].ena; ifb.start = tbl[i].start;
        ifb.mode = tbl[i].mode; ifb.words = tbl[i].words[15:0];
      end
      @(negedge clk);
      check_outs($sformatf("%s[%0d]", tag, i), sel, tbl[i].exp_byte,
                 tbl[i].exp_fe, tbl[i].exp_busy, tbl[i].exp_ready);
    end
    tbl.delete();
    idle_drive();
  endtask

  initial begin
    logic [7:0] b;
    idle_drive();
    ref_word = 32'h12345678;
    ref_idx  = 3'd0;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_outs("rst_a", 0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_outs("rst_b", 1, 8'h00, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs($sformatf("post_rst[%0d]", i), 0, 8'h00, 1'b0, 1'b0, 1'b1);
    end

    ref_idx = 3'd7; #1 check("sel7", ref_nib, 4'h1);
    ref_idx = 3'd0; #1 check("sel0", ref_nib, 4'h8);
    ref_idx = 3'd3; #1 check("sel3", ref_nib, 4'h5);
    @(negedge clk);

    // single frame, back-to-back pending frame, overflow start, start on the pull edge
    add(1'b1, 1'b1, 3'd5, WA, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      b = 8'hB0 | 8'(n & 15);
      if (n == 2)      add(1'b1, 1'b1, 3'd0, WB, b, 1'b0, 1'b1, 1'b0);
      else if (n == 5) add(1'b1, 1'b1, 3'd7, WX, b, 1'b0, 1'b1, 1'b0);
      else             add(1'b1, 1'b0, 3'd0, 64'd0, b, 1'b0, 1'b1, (n == 1));
    end
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'hB0, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 3'd3, WX, 8'h1F, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 7; n++) add(1'b1, 1'b0, 3'd0, 64'd0, 8'h1F, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 8; n++) add(1'b1, 1'b0, 3'd0, 64'd0, 8'h10, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'h10, 1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    run_table(0, "b2b");

    // enable pause after 0xB3; a start during the pause must not be accepted
    add(1'b1, 1'b1, 3'd5, WA, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int n = 1; n <= 3; n++) add(1'b1, 1'b0, 3'd0, 64'd0, 8'hB0 | 8'(n), 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 3'd3, WB, 8'h00, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int n = 4; n <= 16; n++) add(1'b1, 1'b0, 3'd0, 64'd0, 8'hB0 | 8'(n & 15), 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'hB0, 1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    run_table(0, "pause");

    // W=16, N_WORDS=1, no checksum: four bytes, frame_end on the fourth
    add(1'b1, 1'b1, 3'd5, 64'h000000000000ABCD, 8'h00, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'hBA, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'hBB, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'hBC, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'hBD, 1'b1, 1'b1, 1'b1);
    add(1'b1, 1'b0, 3'd0, 64'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    run_table(1, "small");

    // reset mid-frame with a pending frame queued
    ifa.start = 1'b1; ifa.mode = 3'd5; ifa.words = WA;
    @(negedge clk);
    ifa.start = 1'b0;
    @(negedge clk);
    ifa.start = 1'b1; ifa.mode = 3'd0; ifa.words = WB;
    @(negedge clk);
    ifa.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_outs("mid_b5", 0, 8'hB5, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1 check_outs("mid_rst", 0, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs($sformatf("mid_lost[%0d]", i), 0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    ifa.start = 1'b1; ifa.mode = 3'd2; ifa.words = WA;
    @(negedge clk);
    ifa.start = 1'b0;
    check_outs("fresh0", 0, 8'h00, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_outs("fresh1", 0, 8'h51, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_outs("fresh2", 0, 8'h52, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
